pixel_frame_writer: RTL
=======================

PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

Interface
REQ-001 SHALL have parameter H_RES, default 320, frame width in pixels.
REQ-002 SHALL have parameter V_RES, default 180, frame height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, input pixel FIFO entries (power of two).
REQ-004 SHALL have port clk_in  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports x_in  input  11 and y_in  input  10, pixel coordinates of the upstream shaded-pixel stream.
REQ-007 SHALL have ports r_in, g_in, b_in  input  4 each, pixel colour.
REQ-008 SHALL have port valid_in  input  1, one pixel offered per high cycle; upstream cannot stall.
REQ-009 SHALL have port ready_out  output  1, high when the FIFO is not full.
REQ-010 SHALL have port mem_addr_out  output  ADDR_W+1, {bank, y*H_RES+x}, ADDR_W = clog2(H_RES*V_RES).
REQ-011 SHALL have port mem_data_out  output  12, {r,g,b}.
REQ-012 SHALL have ports mem_we_out  output  1 and mem_ready_in  input  1, write request and completion.
REQ-013 SHALL have port display_bank_out  output  1, bank currently owned by the display reader.
REQ-014 SHALL have port frame_done_out  output  1, single-cycle pulse on bank swap.
REQ-015 SHALL have ports drop_count_out  output  16 (FIFO-full drops) and oor_count_out  output  16 (out-of-range discards), both saturating.

Function
REQ-016 SHALL accept a pixel when valid_in is high and the FIFO is not full, in-range test being x_in < H_RES and y_in < V_RES.
REQ-017 SHALL discard out-of-range pixels without FIFO entry, incrementing oor_count_out.
REQ-018 SHALL discard in-range pixels offered while the FIFO is full, incrementing drop_count_out; no existing entry overwritten.
REQ-019 SHALL compute the linear address y*H_RES+x before FIFO entry, storing {address, rgb}.
REQ-020 SHALL present a write on the memory port no earlier than one cycle after acceptance (registered head).
REQ-021 SHALL hold mem_addr_out, mem_data_out, mem_we_out stable while mem_we_out=1 and mem_ready_in=0.
REQ-022 SHALL complete a write on any cycle with mem_we_out=1 and mem_ready_in=1, then pop the next entry with no bubble if one is available.
REQ-023 SHALL always write to bank !display_bank_out.
REQ-024 SHALL count completed writes in a frame counter; duplicate coordinates count each time.
REQ-025 SHALL use FSM states RUN and SWAP: RUN->SWAP when a completed write makes the counter equal H_RES*V_RES; SWAP->RUN after exactly one cycle.
REQ-026 SHALL, in SWAP, toggle display_bank_out, pulse frame_done_out, clear the frame counter, and hold mem_we_out low; FIFO keeps accepting.
REQ-027 SHALL handle simultaneous push and pop on a full FIFO as a push accepted (pop frees the slot in the same cycle).
REQ-028 SHALL saturate both 16-bit counters at 65535.

Reset
REQ-029 SHALL on rst_in=1 empty the FIFO, enter RUN, clear frame counter, drop_count_out=0, oor_count_out=0, display_bank_out=0, frame_done_out=0, mem_we_out=0, ready_out=1 next cycle.
REQ-030 SHALL abandon any in-flight memory write on reset mid-transfer; mem_we_out low the cycle after rst_in is sampled high.

Structure
REQ-031 SHALL place RGB width (4), packed pixel width (12), and the FSM state typedef in the shared project package.
REQ-032 SHALL instantiate one sub-module, pixel_fifo, a synchronous FIFO with full/empty and registered head output.

Verification
REQ-033 Single pixel x=100,y=50,rgb=F/0/A, mem_ready_in=1 -> one write, addr {1,16100}, data 0xF0A, within 3 cycles.
REQ-034 Nine consecutive in-range pixels, mem_ready_in=0 for 20 cycles -> ready_out low after 8, drop_count_out=1, then 8 ordered writes once ready.
REQ-035 Pixel x=320,y=0 and x=0,y=180 -> no writes, oor_count_out=2.
REQ-036 H_RES=4,V_RES=2 instance, 8 pixels -> frame_done_out one pulse, display_bank_out 0->1, next pixel written to bank 0.
REQ-037 mem_ready_in toggling 0/1 each cycle during a write -> address/data stable until acceptance, no duplicated or lost writes.
REQ-038 rst_in asserted with 4 entries queued and a write pending -> mem_we_out low next cycle, all counters 0, no further writes.

Source files
------------

// File: rtl/pixel_frame_writer_pkg.sv
// ============================================================================
//  Module      : pixel_frame_writer_pkg
//  Description : Shared widths, FSM state type and helpers for the frame writer
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_frame_writer_pkg;

   localparam int RGB_W = 4;
   localparam int PIX_W = 3 * RGB_W;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_SWAP = 1'b1
   } fsm_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_fifo.sv
// ============================================================================
//  Module      : pixel_fifo
//  Description : Synchronous FIFO; the head entry is read from flop storage
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_fifo #(
   parameter int WIDTH = 28,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int c_PTR_W = $clog2(DEPTH);

   logic [c_PTR_W:0]  wr_ptr_q;
   logic [c_PTR_W:0]  rd_ptr_q;
   logic [WIDTH-1:0]  mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // When full, push and pop share a slot: the head is consumed on the same edge.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q[c_PTR_W-1:0]] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q[c_PTR_W-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[c_PTR_W] != rd_ptr_q[c_PTR_W]) &&
                    (wr_ptr_q[c_PTR_W-1:0] == rd_ptr_q[c_PTR_W-1:0]);

endmodule

`default_nettype wire

// File: rtl/pixel_frame_writer.sv
// ============================================================================
//  Module      : pixel_frame_writer
//  Description : Buffers shaded pixels and writes them into a double-buffered
//                frame memory, swapping banks after every full frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_frame_writer
   import pixel_frame_writer_pkg::*;
#(
   parameter int H_RES      = 320,
   parameter int V_RES      = 180,
   parameter int FIFO_DEPTH = 8,
   localparam int ADDR_W    = $clog2(H_RES * V_RES)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [10:0]       x_in,
   input  logic [9:0]        y_in,
   input  logic [RGB_W-1:0]  r_in,
   input  logic [RGB_W-1:0]  g_in,
   input  logic [RGB_W-1:0]  b_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [ADDR_W:0]   mem_addr_out,
   output logic [PIX_W-1:0]  mem_data_out,
   output logic              mem_we_out,
   input  logic              mem_ready_in,
   output logic              display_bank_out,
   output logic              frame_done_out,
   output logic [15:0]       drop_count_out,
   output logic [15:0]       oor_count_out
);

   localparam int          c_FRAME_PIX = H_RES * V_RES;
   localparam int          c_CNT_W     = $clog2(c_FRAME_PIX + 1);
   localparam int          c_ENTRY_W   = ADDR_W + PIX_W;
   localparam logic [10:0] c_H_LIM     = 11'(H_RES);
   localparam logic [9:0]  c_V_LIM     = 10'(V_RES);

   fsm_state_e             state_q, state_d;
   logic [c_CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
   logic                   bank_q, bank_d;
   logic [15:0]            drop_cnt_q;
   logic [15:0]            oor_cnt_q;

   logic                   in_range_w;
   logic [ADDR_W-1:0]      lin_addr_w;
   logic                   push_w;
   logic                   pop_w;
   logic                   fifo_full_w;
   logic                   fifo_empty_w;
   logic [c_ENTRY_W-1:0]   head_w;
   logic                   mem_we_w;
   logic                   frame_done_w;

   assign in_range_w = (x_in < c_H_LIM) && (y_in < c_V_LIM);
   assign lin_addr_w = ADDR_W'(y_in) * ADDR_W'(H_RES) + ADDR_W'(x_in);
   assign pop_w      = mem_we_w & mem_ready_in;
   // A completing write frees a slot, so a full FIFO can still take a pixel.
   assign push_w     = valid_in & in_range_w & (~fifo_full_w | pop_w);

   pixel_fifo #(
      .WIDTH (c_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .push_i  (push_w),
      .data_i  ({lin_addr_w, r_in, g_in, b_in}),
      .pop_i   (pop_w),
      .head_o  (head_w),
      .full_o  (fifo_full_w),
      .empty_o (fifo_empty_w)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= ST_RUN;
         frame_cnt_q <= '0;
         bank_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         bank_q      <= bank_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = frame_cnt_q;
      bank_d       = bank_q;
      mem_we_w     = 1'b0;
      frame_done_w = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            mem_we_w = ~fifo_empty_w;
            if (~fifo_empty_w && mem_ready_in) begin
               frame_cnt_d = frame_cnt_q + c_CNT_W'(1);
               if (frame_cnt_q == c_CNT_W'(c_FRAME_PIX - 1)) state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            frame_done_w = 1'b1;
            frame_cnt_d  = '0;
            bank_d       = ~bank_q;
            state_d      = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drop_cnt_q <= '0;
         oor_cnt_q  <= '0;
      end else begin
         if (valid_in && in_range_w && !push_w) drop_cnt_q <= sat_inc16(drop_cnt_q);
         if (valid_in && !in_range_w)           oor_cnt_q  <= sat_inc16(oor_cnt_q);
      end
   end

   assign ready_out        = ~fifo_full_w;
   assign mem_we_out       = mem_we_w;
   assign mem_addr_out     = {~bank_q, head_w[c_ENTRY_W-1:PIX_W]};
   assign mem_data_out     = head_w[PIX_W-1:0];
   assign display_bank_out = bank_q;
   assign frame_done_out   = frame_done_w;
   assign drop_count_out   = drop_cnt_q;
   assign oor_count_out    = oor_cnt_q;

endmodule

`default_nettype wire
